// File: rtl/multiport_reg_file.sv
// Multi-port register file with write-to-read bypass, optional hardwired zero
// register and a per-register busy scoreboard for producer/consumer hazards.
module multiport_reg_file #(
    parameter int unsigned N        = 32,
    parameter int unsigned M        = 32,
    parameter int unsigned NR       = 2,
    parameter int unsigned NW       = 2,
    parameter bit          ZERO_REG = 1'b1,
    localparam int unsigned A       = $clog2(M)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NW-1:0]          Wen,
    input  logic [NW-1:0][A-1:0]   Wreg,
    input  logic [NW-1:0][N-1:0]   Wdata,
    input  logic [NR-1:0][A-1:0]   Rreg,
    output logic [NR-1:0][N-1:0]   Rdata,
    output logic [NR-1:0]          Rbusy,
    input  logic                   Issue,
    input  logic [A-1:0]           IssueReg,
    output logic [M-1:0]           busy_vec
);

    logic [M-1:0][N-1:0] regs;
    logic [M-1:0]        wr_hit;
    logic [M-1:0][N-1:0] wr_val;
    logic [M-1:0]        issue_hit;
    logic [M-1:0]        busy_next;

    // Per-register write resolution; later ports overwrite earlier ones so the
    // highest-index port wins. Gated by rst so reads are 0 while in reset.
    always_comb begin : write_resolve
        wr_hit = '0;
        wr_val = '0;
        for (int i = 0; i < int'(M); i++) begin
            for (int w = 0; w < int'(NW); w++) begin
                if (rst && Wen[w] && (Wreg[w] == A'(i))) begin
                    wr_hit[i] = 1'b1;
                    wr_val[i] = Wdata[w];
                end
            end
        end
        if (ZERO_REG) begin
            wr_hit[0] = 1'b0;
        end
    end

    // Zero-latency read ports with bypass and hazard status
    always_comb begin : read_ports
        Rdata = '0;
        Rbusy = '0;
        for (int r = 0; r < int'(NR); r++) begin
            if (wr_hit[Rreg[r]]) begin
                Rdata[r] = wr_val[Rreg[r]];
            end else begin
                Rdata[r] = regs[Rreg[r]];
            end
            if (ZERO_REG && (Rreg[r] == '0)) begin
                Rdata[r] = '0;
            end
            Rbusy[r] = busy_vec[Rreg[r]] & ~wr_hit[Rreg[r]];
        end
    end

    // Scoreboard next state: a new issue outranks a completing write
    always_comb begin : busy_update
        issue_hit = '0;
        busy_next = '0;
        for (int i = 0; i < int'(M); i++) begin
            issue_hit[i] = Issue && (IssueReg == A'(i));
            busy_next[i] = issue_hit[i] | (busy_vec[i] & ~wr_hit[i]);
        end
        if (ZERO_REG) begin
            busy_next[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin : state_regs
        if (!rst) begin
            regs     <= '0;
            busy_vec <= '0;
        end else begin
            for (int i = 0; i < int'(M); i++) begin
                if (wr_hit[i]) begin
                    regs[i] <= wr_val[i];
                end
            end
            busy_vec <= busy_next;
        end
    end

endmodule

// File: doc/multiport_reg_file.md
Name: multiport_reg_file

Overview:
Parametrised successor to the datapath register bank. It adds:
- configurable read and write port counts;
- optional hardwired zero register;
- same-cycle write-to-read bypass;
- per-register busy scoreboard for producer/consumer hazard tracking.

It sits between decode and execute and feeds operand data and hazard status to the control unit.

Parameters:
N, 32, data width in bits
M, 32, number of registers (power of 2, >= 2); A = $clog2(M)
NR, 2, number of read ports (>= 1)
NW, 2, number of write ports (>= 1)
ZERO_REG, 1, 1 = register 0 always reads 0, ignores writes, never busy

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
Wen  in  NW  per-write-port enable
Wreg  in  NW x A  per-write-port target register
Wdata  in  NW x N  per-write-port data
Rreg  in  NR x A  per-read-port source register
Rdata  out  NR x N  per-read-port data (combinational)
Rbusy  out  NR  per-read-port: source has a pending producer
Issue  in  1  mark IssueReg busy (new in-flight producer)
IssueReg  in  A  register being claimed
busy_vec  out  M  registered scoreboard state

Behaviour:
- Reset: rst low asynchronously clears all registers to 0 and busy_vec to 0.
  - Rdata and Rbusy are combinational, so they read 0 during reset.
- Write: on the rising edge, for each port w with Wen[w]=1, reg[Wreg[w]] <= Wdata[w].
  - If several ports target the same register, the highest-index port wins.
  - When ZERO_REG=1, writes to reg 0 are discarded.
- Read: zero latency.
  - Rdata[r] = bypass value if any enabled write port targets Rreg[r] this cycle, using the same highest-index-wins rule; otherwise reg[Rreg[r]].
  - When ZERO_REG=1 and Rreg[r]=0, Rdata[r]=0 regardless of writes.
- Scoreboard, next-state per register i on the rising edge:
  - Issue=1 and IssueReg=i: busy[i] <= 1. Issue has priority over a same-cycle write completion, because it is a new producer.
  - Otherwise, any enabled write to i: busy[i] <= 0.
  - Otherwise: busy[i] holds.
  - When ZERO_REG=1, busy[0] is held 0 permanently and Issue to 0 is ignored.
- Rbusy[r] = busy[Rreg[r]] and not (any enabled write to Rreg[r] this cycle).
  - This means the bypass clears the hazard in the completing cycle.
  - A same-cycle Issue to the same register does not affect Rbusy in that cycle.
- Write to a non-busy register is legal: data is updated and busy stays 0.
- Issue to an already-busy register is legal and keeps busy=1; there is no counting, the last producer owns it.
- Mid-operation reset (rst falling at any time) clears state immediately; the first edge after rst rises behaves as a normal cycle.
- No X propagation: all combinational outputs are fully assigned for every input combination.

Test Plan:
1. Reset/zero: assert rst=0 mid-run after writing 0xDEAD_BEEF to reg 5 → Rdata=0 and busy_vec=0 immediately. Release, read reg 5 → 0.
2. Write/read and zero register: Wen[0]=1, Wreg=3, Wdata=0x1234; Wen[1]=1, Wreg=0, Wdata=0xFFFF.
   - Next cycle: Rreg0=3 gives 0x1234; Rreg1=0 gives 0.
   - Same with ZERO_REG=0: reg 0 reads 0xFFFF.
3. Write conflict and bypass: both ports write reg 7 (port0 0xAAAA, port1 0x5555) with Rreg0=7 in the same cycle.
   - Same cycle: Rdata0=0x5555.
   - Next cycle: reg 7 = 0x5555.
4. Scoreboard lifecycle:
   - Issue reg 9 → next cycle busy_vec[9]=1 and Rbusy=1 for Rreg=9.
   - Write 0x42 to reg 9: in the write cycle Rbusy=0 and Rdata=0x42; next cycle busy_vec[9]=0.
5. Simultaneous issue and write: busy[4]=1; same cycle Issue reg 4 and write 0x77 to reg 4.
   - Next cycle: busy_vec[4]=1 and reg 4 = 0x77.
   - Also: Issue to reg 0 with ZERO_REG=1 → busy_vec[0] stays 0.
6. Parameter sweep with N=16, M=8, NR=3, NW=1: random write/issue/read streams compared against a reference model, with all three read ports aliasing the same register.
